// File: rtl/trace_arbiter.sv
// Round-robin arbiter that funnels NUM_SOURCES trace streams into one trace
// buffer write port, with credit tracking of buffer occupancy and drain/flush.

package ryuki_datatypes;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } trace_output;
endpackage

module trace_arbiter_lane #(
  parameter int PW  = 2,
  parameter int IDX = 0
) (
  input  logic          valid,
  input  logic [PW-1:0] rr_ptr,
  output logic          req_hi
);
  localparam logic [PW-1:0] IDX_V = PW'(IDX);

  // Request at or after the round-robin pointer gets first pick.
  assign req_hi = valid && (IDX_V >= rr_ptr);
endmodule

module trace_arbiter
  import ryuki_datatypes::*;
#(
  parameter int NUM_SOURCES  = 4,
  parameter int BUFFER_WIDTH = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            enable,
  input  logic                            flush_req,
  input  logic [NUM_SOURCES-1:0]          src_valid,
  input  trace_output [NUM_SOURCES-1:0]   src_data,
  output logic [NUM_SOURCES-1:0]          src_ready,
  output logic                            buf_write,
  output trace_output                     buf_data,
  input  logic                            buf_read_done,
  output logic [$clog2(BUFFER_WIDTH):0]   occupancy,
  output logic                            flush_done,
  output logic                            underflow_err
);
  localparam int PW = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1;
  localparam int OW = $clog2(BUFFER_WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                 state;
  logic [PW-1:0]          rr_ptr;
  logic [NUM_SOURCES-1:0] req_hi;
  logic [NUM_SOURCES-1:0] grant;
  logic [PW-1:0]          grant_idx;
  logic                   found;
  logic                   can_grant;
  logic                   acc;
  logic                   rd_eff;

  genvar g;
  for (g = 0; g < NUM_SOURCES; g++) begin : g_lane
    trace_arbiter_lane #(.PW(PW), .IDX(g)) u_lane (
      .valid  (src_valid[g]),
      .rr_ptr (rr_ptr),
      .req_hi (req_hi[g])
    );
  end

  // A same-cycle read release frees a slot, so a full buffer can still grant.
  assign can_grant = (state == RUN) && enable && !flush_req &&
                     ((occupancy < OW'(BUFFER_WIDTH)) || buf_read_done);

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    for (int i = 0; i < NUM_SOURCES; i++) begin
      if (!found && req_hi[i]) begin
        grant[i]  = 1'b1;
        grant_idx = PW'(i);
        found     = 1'b1;
      end
    end
    for (int i = 0; i < NUM_SOURCES; i++) begin
      if (!found && src_valid[i]) begin
        grant[i]  = 1'b1;
        grant_idx = PW'(i);
        found     = 1'b1;
      end
    end
    if (!can_grant) grant = '0;
  end

  assign src_ready = grant;
  assign acc       = |grant;
  assign rd_eff    = buf_read_done && (occupancy != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      occupancy     <= '0;
      buf_write     <= 1'b0;
      buf_data      <= '0;
      flush_done    <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      flush_done <= 1'b0;
      buf_write  <= acc;
      if (acc) begin
        buf_data <= src_data[grant_idx];
        rr_ptr   <= (grant_idx == PW'(NUM_SOURCES - 1)) ? '0 : grant_idx + PW'(1);
      end

      case ({acc, rd_eff})
        2'b10:   occupancy <= occupancy + OW'(1);
        2'b01:   occupancy <= occupancy - OW'(1);
        default: occupancy <= occupancy;
      endcase

      if (buf_read_done && (occupancy == '0)) underflow_err <= 1'b1;

      case (state)
        IDLE:    if (flush_req) state <= DRAIN;
                 else if (enable) state <= RUN;
        RUN:     if (flush_req) state <= DRAIN;
                 else if (!enable) state <= IDLE;
        DRAIN:   if (occupancy == '0) begin
                   state      <= IDLE;
                   flush_done <= 1'b1;
                 end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_trace_arbiter.sv
// Directed bench for trace_arbiter: expected grants are constants, accepted
// elements go through a scoreboard queue and are matched against buf_data.
module tb_trace_arbiter;
  import ryuki_datatypes::*;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  enable;
  logic                  flush_req;
  logic [3:0]            src_valid;
  trace_output [3:0]     sd;
  logic [3:0]            src_ready;
  logic                  buf_write;
  trace_output           buf_data;
  logic                  buf_read_done;
  logic [3:0]            occupancy;
  logic                  flush_done;
  logic                  underflow_err;

  int errors = 0;
  int checks = 0;
  int stepn  = 0;
  logic [63:0] sb[$];

  trace_arbiter #(.NUM_SOURCES(4), .BUFFER_WIDTH(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .flush_req     (flush_req),
    .src_valid     (src_valid),
    .src_data      (sd),
    .src_ready     (src_ready),
    .buf_write     (buf_write),
    .buf_data      (buf_data),
    .buf_read_done (buf_read_done),
    .occupancy     (occupancy),
    .flush_done    (flush_done),
    .underflow_err (underflow_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with inputs already set; checks one full cycle.
  task automatic cyc(input logic [3:0] er, input int eo, input logic efd);
    stepn++;
    for (int i = 0; i < 4; i++) begin
      sd[i].pc    = 32'(stepn * 32'h1000 + i);
      sd[i].instr = ~sd[i].pc;
    end
    #1;
    chk("src_ready", src_ready, er);
    for (int i = 0; i < 4; i++) if (er[i]) sb.push_back(sd[i]);
    @(posedge clk); #1;
    if (sb.size() != 0) begin
      chk("buf_write", buf_write, 1'b1);
      chk("buf_data", buf_data, sb.pop_front());
    end else begin
      chk("buf_write_idle", buf_write, 1'b0);
    end
    chk("occupancy", occupancy, 64'(eo));
    chk("flush_done", flush_done, efd);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; flush_req = 1'b0; src_valid = '0;
    buf_read_done = 1'b0; sd = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", src_ready, 4'b0);
    chk("rst_write", buf_write, 1'b0);
    chk("rst_data", buf_data, 64'h0);
    chk("rst_occ", occupancy, 4'd0);
    chk("rst_fdone", flush_done, 1'b0);
    chk("rst_uflow", underflow_err, 1'b0);

    // Full-rate fill: one cycle to enter RUN, then eight round-robin grants.
    rst = 1'b0; enable = 1'b1; src_valid = 4'b1111;
    cyc(4'b0000, 0, 1'b0);
    cyc(4'b0001, 1, 1'b0); cyc(4'b0010, 2, 1'b0);
    cyc(4'b0100, 3, 1'b0); cyc(4'b1000, 4, 1'b0);
    cyc(4'b0001, 5, 1'b0); cyc(4'b0010, 6, 1'b0);
    cyc(4'b0100, 7, 1'b0); cyc(4'b1000, 8, 1'b0);
    cyc(4'b0000, 8, 1'b0); cyc(4'b0000, 8, 1'b0);

    // Full buffer: read release allows a same-cycle grant.
    src_valid = 4'b0100; buf_read_done = 1'b1;
    cyc(4'b0100, 8, 1'b0);
    buf_read_done = 1'b0;
    cyc(4'b0000, 8, 1'b0);

    // Empty the buffer with no requests.
    src_valid = 4'b0000; buf_read_done = 1'b1;
    for (int k = 7; k >= 0; k--) cyc(4'b0000, k, 1'b0);

    // Wrap to source 1 (pointer at 3), then alternate 3/1 from pointer 2.
    buf_read_done = 1'b0; src_valid = 4'b0010;
    cyc(4'b0010, 1, 1'b0);
    src_valid = 4'b1010;
    cyc(4'b1000, 2, 1'b0); cyc(4'b0010, 3, 1'b0);
    cyc(4'b1000, 4, 1'b0); cyc(4'b0010, 5, 1'b0);

    // Enable drop: no grant that cycle, pending write still issues.
    enable = 1'b0;
    cyc(4'b0000, 5, 1'b0);
    enable = 1'b1;
    cyc(4'b0000, 5, 1'b0);
    cyc(4'b1000, 6, 1'b0);

    // Bring occupancy to 3 with a grant just before the flush.
    src_valid = 4'b0000; buf_read_done = 1'b1;
    cyc(4'b0000, 5, 1'b0); cyc(4'b0000, 4, 1'b0);
    cyc(4'b0000, 3, 1'b0); cyc(4'b0000, 2, 1'b0);
    buf_read_done = 1'b0; src_valid = 4'b0001;
    cyc(4'b0001, 3, 1'b0);
    flush_req = 1'b1;
    cyc(4'b0000, 3, 1'b0);
    flush_req = 1'b0; buf_read_done = 1'b1;
    cyc(4'b0000, 2, 1'b0); cyc(4'b0000, 1, 1'b0); cyc(4'b0000, 0, 1'b0);
    buf_read_done = 1'b0;
    cyc(4'b0000, 0, 1'b1);
    cyc(4'b0000, 0, 1'b0);
    cyc(4'b0001, 1, 1'b0);

    // Flush from IDLE with an empty buffer.
    enable = 1'b0; src_valid = 4'b0000; buf_read_done = 1'b1;
    cyc(4'b0000, 0, 1'b0);
    buf_read_done = 1'b0; flush_req = 1'b1;
    cyc(4'b0000, 0, 1'b0);
    flush_req = 1'b0;
    cyc(4'b0000, 0, 1'b1);
    cyc(4'b0000, 0, 1'b0);
    chk("uflow_clear", underflow_err, 1'b0);

    // Read release on an empty buffer is sticky.
    buf_read_done = 1'b1;
    cyc(4'b0000, 0, 1'b0);
    chk("uflow_set", underflow_err, 1'b1);
    buf_read_done = 1'b0;
    cyc(4'b0000, 0, 1'b0); cyc(4'b0000, 0, 1'b0);
    chk("uflow_hold", underflow_err, 1'b1);

    // Grant source 1, then reset right behind it: the write is discarded.
    enable = 1'b1; src_valid = 4'b0010;
    cyc(4'b0000, 0, 1'b0);
    #1 chk("pre_rst_ready", src_ready, 4'b0010);
    @(posedge clk); #1 rst = 1'b1;
    #1;
    chk("arst_ready", src_ready, 4'b0);
    chk("arst_write", buf_write, 1'b0);
    chk("arst_data", buf_data, 64'h0);
    chk("arst_occ", occupancy, 4'd0);
    chk("arst_fdone", flush_done, 1'b0);
    chk("arst_uflow", underflow_err, 1'b0);
    sb.delete();
    @(negedge clk);
    chk("rst_hold_write", buf_write, 1'b0);
    enable = 1'b0; src_valid = 4'b0000;
    @(negedge clk);
    rst = 1'b0;
    cyc(4'b0000, 0, 1'b0); cyc(4'b0000, 0, 1'b0); cyc(4'b0000, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/trace_arbiter.md
TRACE_ARBITER -- requirements
Module: trace_arbiter

Interface
REQ-001 Parameter NUM_SOURCES, default 4, number of trace requesters sharing one trace buffer write port.
REQ-002 Parameter BUFFER_WIDTH, default 8, depth of downstream trace buffer (credit limit).
REQ-003 clk  input  1  system clock; all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 enable  input  1  arbitration enable; low = no new grants.
REQ-006 flush_req  input  1  single-cycle pulse requesting drain-and-stop.
REQ-007 src_valid  input  NUM_SOURCES  per-source element available.
REQ-008 src_data  input  NUM_SOURCES x trace_output  per-source trace element (ryuki_datatypes::trace_output).
REQ-009 src_ready  output  NUM_SOURCES  one-hot-or-zero accept strobe; element taken when src_valid[i] && src_ready[i].
REQ-010 buf_write  output  1  one-cycle write strobe to trace buffer ready_signal.
REQ-011 buf_data  output  trace_output  element presented with buf_write.
REQ-012 buf_read_done  input  1  one-cycle pulse: buffer released one entry to consumer.
REQ-013 occupancy  output  clog2(BUFFER_WIDTH)+1  entries reserved in buffer.
REQ-014 flush_done  output  1  one-cycle pulse: flush complete.
REQ-015 underflow_err  output  1  sticky: buf_read_done seen with occupancy 0.

Function
REQ-016 FSM states IDLE, RUN, DRAIN; IDLE->RUN when enable=1; RUN->IDLE when enable=0; RUN or IDLE -> DRAIN on flush_req; DRAIN->IDLE when occupancy==0 (flush_done pulses that cycle).
REQ-017 Grants issued only in RUN, and only when occupancy < BUFFER_WIDTH after counting this cycle's buf_read_done.
REQ-018 src_ready combinational from registered state: at most one bit high, the first requesting source at or after rr_ptr in ascending index order, wrapping NUM_SOURCES-1 -> 0.
REQ-019 On acceptance of source i, rr_ptr <= (i+1) mod NUM_SOURCES; rr_ptr unchanged when nothing accepted.
REQ-020 Accepted element registered: buf_write=1 and buf_data=src_data[i] exactly one cycle after acceptance; buf_write low otherwise, buf_data holds last value.
REQ-021 At most one acceptance per cycle; maximum throughput one element per cycle.
REQ-022 occupancy increments on acceptance (reservation), decrements on buf_read_done; both same cycle -> unchanged.
REQ-023 occupancy never exceeds BUFFER_WIDTH; when occupancy==BUFFER_WIDTH and buf_read_done arrives, a grant is allowed the same cycle.
REQ-024 buf_read_done with occupancy==0 and no acceptance: occupancy stays 0, underflow_err set until reset.
REQ-025 flush_req in RUN: acceptance in that cycle is suppressed; the pending registered write, if any, still issues.
REQ-026 flush_req while already in DRAIN ignored; enable ignored in DRAIN.
REQ-027 DRAIN entered with occupancy 0: flush_done pulses the following cycle, return to IDLE.
REQ-028 enable falling in RUN: no acceptance that cycle; registered write already pending still issues.

Reset
REQ-029 On rst assertion, immediately: state IDLE, rr_ptr 0, occupancy 0, src_ready 0, buf_write 0, buf_data 0, flush_done 0, underflow_err 0.
REQ-030 rst mid-transfer discards the pending registered write; no buf_write after reset release until a new acceptance.
REQ-031 First grant possible in the second cycle after rst deasserts with enable=1 (one cycle to enter RUN).

Verification
REQ-032 Reset, enable=1, src_valid=4'b1111 held, no reads -> grants to sources 0,1,2,3,0,1,2,3 then src_ready=0, occupancy=8, eight buf_write pulses each one cycle after its grant.
REQ-033 occupancy=8, src_valid=4'b0100, buf_read_done pulse -> same-cycle grant to source 2, occupancy stays 8.
REQ-034 occupancy=3, flush_req pulse with src_valid=4'b0001 -> no further grants, three buf_read_done pulses -> flush_done one cycle after occupancy reaches 0, state IDLE.
REQ-035 occupancy=0, buf_read_done pulse -> underflow_err=1, occupancy=0; stays 1 until rst.
REQ-036 Grant to source 1 then rst asserted next cycle -> buf_write never asserted, all outputs at reset values.
REQ-037 src_valid=4'b1010, rr_ptr=2 -> grant source 3, then source 1, then source 3 alternating.
